// File: rtl/add_sub_stage3_pkg.sv
// Shared constants for the floating-point add/subtract path and its
// multiply/divide siblings.
package add_sub_stage3_pkg;

    localparam int DataSize     = 32;
    localparam int FractionSize = 23;
    localparam int MantissaSize = FractionSize + 1;
    localparam int RoundingSize = MantissaSize + 3;
    localparam int ExponentSize = 8;

    localparam logic [ExponentSize-1:0] ExpInf  = 8'hFF;
    localparam int                      ExpBias = 127;

endpackage

// File: rtl/add_sub_stage3_lzc.sv
// Leading-zero counter used by the add/subtract normaliser; also reusable by
// the multiply/divide normaliser. An all-zero input returns Width.
module leading_zero_counter
    import add_sub_stage3_pkg::*;
#(
    parameter int Width     = RoundingSize,
    parameter int CountSize = 5
) (
    input  logic [Width-1:0]     value,
    output logic [CountSize-1:0] count
);

    // Scanning upward lets the highest set bit win.
    always_comb begin
        count = CountSize'(Width);
        for (int unsigned i = 0; i < Width; i++) begin
            if (value[i]) begin
                count = CountSize'(Width - 1 - i);
            end
        end
    end

endmodule

// File: rtl/add_sub_stage3.sv
// Third add/subtract stage: significand add, normalise, round-to-nearest-even,
// exponent adjust and pack, across two back-pressurable register stages.
module add_sub_stage3
    import add_sub_stage3_pkg::*;
#(
    parameter int DataSize     = add_sub_stage3_pkg::DataSize,
    parameter int FractionSize = add_sub_stage3_pkg::FractionSize,
    parameter int MantissaSize = add_sub_stage3_pkg::MantissaSize,
    parameter int RoundingSize = add_sub_stage3_pkg::RoundingSize,
    parameter int ExponentSize = add_sub_stage3_pkg::ExponentSize
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    InValid,
    output logic                    InReady,
    input  logic [RoundingSize-1:0] Adder1,
    input  logic [RoundingSize-1:0] Adder2,
    input  logic [ExponentSize-1:0] ExponentBase,
    input  logic                    EffOperation,
    input  logic                    ResultSign,
    output logic                    OutValid,
    input  logic                    OutReady,
    output logic [DataSize-1:0]     Result,
    output logic                    Overflow,
    output logic                    Underflow
);

    localparam int SumSize     = RoundingSize + 1;
    localparam int ExpCalcSize = ExponentSize + 2;
    localparam int CountSize   = 5;
    localparam int MantRndSize = MantissaSize + 1;

    logic                    adv_a;
    logic                    adv_b;
    logic                    valid_a;
    logic [SumSize-1:0]      sum_a;
    logic [ExponentSize-1:0] exp_a;
    logic                    op_a;
    logic                    sign_a;

    assign adv_b   = OutReady | ~OutValid;
    assign adv_a   = adv_b | ~valid_a;
    assign InReady = adv_a;

    // Stage A: significand addition
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            valid_a <= 1'b0;
            sum_a   <= '0;
            exp_a   <= '0;
            op_a    <= 1'b0;
            sign_a  <= 1'b0;
        end else if (adv_a) begin
            valid_a <= InValid;
            if (InValid) begin
                sum_a  <= SumSize'(Adder1) + SumSize'(Adder2) + SumSize'(EffOperation);
                exp_a  <= ExponentBase;
                op_a   <= EffOperation;
                sign_a <= ResultSign;
            end
        end
    end

    logic [CountSize-1:0] lzc;
    logic                 sub_zero;

    assign sub_zero = (sum_a[RoundingSize-1:0] == '0);

    leading_zero_counter #(
        .Width     (RoundingSize),
        .CountSize (CountSize)
    ) u_lzc (
        .value (sum_a[RoundingSize-1:0]),
        .count (lzc)
    );

    logic [RoundingSize-1:0]       norm;
    logic                          sticky_norm;
    logic signed [ExpCalcSize-1:0] exp_norm;
    logic signed [ExpCalcSize-1:0] exp_final;
    logic [MantissaSize-1:0]       mant;
    logic [MantRndSize-1:0]        mant_rnd;
    logic [FractionSize-1:0]       frac;
    logic                          guard;
    logic                          round_bit;
    logic                          sticky;
    logic                          round_up;
    logic [DataSize-1:0]           res_next;
    logic                          ovf_next;
    logic                          unf_next;

    // Stage B: normalise
    always_comb begin
        norm        = sum_a[RoundingSize-1:0];
        sticky_norm = 1'b0;
        exp_norm    = ExpCalcSize'(exp_a);
        if (op_a) begin
            norm     = sum_a[RoundingSize-1:0] << lzc;
            exp_norm = ExpCalcSize'(exp_a) - ExpCalcSize'(lzc);
        end else if (sum_a[RoundingSize]) begin
            norm        = sum_a[RoundingSize:1];
            sticky_norm = sum_a[0];
            exp_norm    = ExpCalcSize'(exp_a) + ExpCalcSize'(1);
        end
    end

    // Round to nearest even, then saturate or flush
    always_comb begin
        mant      = norm[RoundingSize-1 -: MantissaSize];
        guard     = norm[2];
        round_bit = norm[1];
        sticky    = norm[0] | sticky_norm;
        round_up  = guard & (round_bit | sticky | mant[0]);
        mant_rnd  = {1'b0, mant} + MantRndSize'(round_up);

        exp_final = exp_norm;
        frac      = mant_rnd[FractionSize-1:0];
        // A carry out of rounding means exactly 2.0; shifting right renormalises to 1.0.
        if (mant_rnd[MantissaSize]) begin
            exp_final = exp_norm + ExpCalcSize'(1);
            frac      = mant_rnd[FractionSize:1];
        end

        res_next = {sign_a, exp_final[ExponentSize-1:0], frac};
        ovf_next = 1'b0;
        unf_next = 1'b0;
        if (op_a && sub_zero) begin
            res_next = '0;
        end else if (exp_final >= $signed(ExpCalcSize'(ExpInf))) begin
            res_next = {sign_a, ExponentSize'(ExpInf), FractionSize'(0)};
            ovf_next = 1'b1;
        end else if (exp_final <= $signed(ExpCalcSize'(0))) begin
            res_next = {sign_a, ExponentSize'(0), FractionSize'(0)};
            unf_next = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            OutValid  <= 1'b0;
            Result    <= '0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else if (adv_b) begin
            OutValid <= valid_a;
            if (valid_a) begin
                Result    <= res_next;
                Overflow  <= ovf_next;
                Underflow <= unf_next;
            end
        end
    end

endmodule

// File: tb/tb_add_sub_stage3.sv
// Directed bench for add_sub_stage3: an arithmetic reference model feeds a
// scoreboard that is compared with the DUT outputs every valid cycle.
module tb_add_sub_stage3;

    logic        Clk;
    logic        Reset;
    logic        InValid;
    logic        InReady;
    logic [26:0] Adder1;
    logic [26:0] Adder2;
    logic [7:0]  ExponentBase;
    logic        EffOperation;
    logic        ResultSign;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] Result;
    logic        Overflow;
    logic        Underflow;

    add_sub_stage3 dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .InValid      (InValid),
        .InReady      (InReady),
        .Adder1       (Adder1),
        .Adder2       (Adder2),
        .ExponentBase (ExponentBase),
        .EffOperation (EffOperation),
        .ResultSign   (ResultSign),
        .OutValid     (OutValid),
        .OutReady     (OutReady),
        .Result       (Result),
        .Overflow     (Overflow),
        .Underflow    (Underflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [26:0] a1;
        logic [26:0] a2;
        logic [7:0]  eb;
        logic        op;
        logic        sg;
        logic [33:0] exp;   // {overflow, underflow, result}
    } vec_t;

    vec_t        vecs[10];
    logic [33:0] sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          popped   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Value-level reference: locate the leading one, scale to 24 bits, round
    // on the discarded remainder against one half.
    function automatic logic [33:0] model(input vec_t v);
        longint s, x, m, rem, half;
        int     p, e;
        logic   up;
        s = longint'(v.a1) + longint'(v.a2) + longint'(v.op);
        if (v.op) begin
            x = s % (longint'(1) << 27);
            if (x == 0) return '0;
            p = 26;
            while (((x >> p) & 1) == 0) p--;
        end else begin
            x = s;
            p = (s >= (longint'(1) << 27)) ? 27 : 26;
        end
        e  = int'(v.eb) + p - 26;
        up = 1'b0;
        if (p >= 24) begin
            m    = x >> (p - 23);
            rem  = x & ((longint'(1) << (p - 23)) - 1);
            half = longint'(1) << (p - 24);
            up   = (rem > half) || (rem == half && (m & 1) == 1);
        end else begin
            m = x << (23 - p);
        end
        if (up) m = m + 1;
        if (m == (longint'(1) << 24)) begin
            m = longint'(1) << 23;
            e = e + 1;
        end
        if (e >= 255) return {1'b1, 1'b0, v.sg, 8'hFF, 23'd0};
        if (e <= 0)   return {1'b0, 1'b1, v.sg, 31'd0};
        return {2'b00, v.sg, e[7:0], m[22:0]};
    endfunction

    function automatic vec_t mk(input logic [26:0] a1, input logic [26:0] a2, input logic [7:0] eb,
                                input logic op, input logic sg, input logic [33:0] exp);
        vec_t v;
        v.a1 = a1; v.a2 = a2; v.eb = eb; v.op = op; v.sg = sg; v.exp = exp;
        return v;
    endfunction

    always @(negedge Clk) begin
        if (!Reset) begin
            if (OutValid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual=%0h required=none", Result);
                end else begin
                    check("sb_result", 64'({Overflow, Underflow, Result}), 64'(sb[0]));
                    if (OutReady) begin
                        void'(sb.pop_front());
                        popped++;
                    end
                end
            end
            if (InValid && InReady) begin
                sb.push_back(model(mk(Adder1, Adder2, ExponentBase, EffOperation, ResultSign, '0)));
            end
        end
    end

    task automatic drive(input int idx);
        Adder1       = vecs[idx].a1;
        Adder2       = vecs[idx].a2;
        ExponentBase = vecs[idx].eb;
        EffOperation = vecs[idx].op;
        ResultSign   = vecs[idx].sg;
    endtask

    task automatic send(input int idx);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        drive(idx);
        InValid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge Clk);
            acc = InReady;
            @(posedge Clk);
            #1;
            n++;
        end
        InValid = 1'b0;
        if (!acc) check("send_timeout", 64'(acc), 64'(1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || OutValid) && n < 40) begin
            @(posedge Clk);
            #1;
            n++;
        end
        check("drain_empty", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        int   k;
        int   c;
        int   p0;
        logic acc;

        vecs[0] = mk(27'h4000000, 27'h4000000, 8'd127, 1'b0, 1'b0, {2'b00, 32'h40000000});
        vecs[1] = mk(27'h3FFFFFF, 27'h4000000, 8'd127, 1'b1, 1'b0, {2'b00, 32'h00000000});
        vecs[2] = mk(27'h0000000, 27'h7FFFFFC, 8'd127, 1'b0, 1'b0, {2'b00, 32'h40000000});
        vecs[3] = mk(27'h0000000, 27'h7FFFFF4, 8'd127, 1'b0, 1'b0, {2'b00, 32'h3FFFFFFE});
        vecs[4] = mk(27'h4000000, 27'h4000000, 8'd254, 1'b0, 1'b0, {2'b10, 32'h7F800000});
        vecs[5] = mk(27'h3FFFFFF, 27'h4800000, 8'd1,   1'b1, 1'b0, {2'b01, 32'h00000000});
        vecs[6] = mk(27'h4000000, 27'h6000000, 8'd127, 1'b0, 1'b0, {2'b00, 32'h40200000});
        vecs[7] = mk(27'h4000009, 27'h4000000, 8'd127, 1'b0, 1'b0, {2'b00, 32'h40000001});
        vecs[8] = mk(27'h3FFFFFF, 27'h6000000, 8'd127, 1'b1, 1'b0, {2'b00, 32'h3F000000});
        vecs[9] = mk(27'h4000000, 27'h4000000, 8'd127, 1'b0, 1'b1, {2'b00, 32'hC0000000});

        Reset    = 1'b1;
        InValid  = 1'b0;
        OutReady = 1'b1;
        drive(0);
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b0;
        #1;
        check("reset_outvalid",  64'(OutValid),  64'(0));
        check("reset_result",    64'(Result),    64'(0));
        check("reset_overflow",  64'(Overflow),  64'(0));
        check("reset_underflow", 64'(Underflow), 64'(0));
        check("reset_inready",   64'(InReady),   64'(1));

        for (int i = 0; i < 10; i++) begin
            check($sformatf("model_pin_%0d", i), 64'(model(vecs[i])), 64'(vecs[i].exp));
        end

        // Latency: two edges from acceptance to OutValid.
        send(0);
        check("latency_edge1_outvalid", 64'(OutValid), 64'(0));
        @(posedge Clk);
        #1;
        check("latency_edge2_outvalid", 64'(OutValid), 64'(1));
        check("latency_edge2_result",   64'(Result),   64'(32'h40000000));
        drain();

        for (int i = 0; i < 10; i++) send(i);
        drain();

        // Back-pressure: three offered, two accepted, then release.
        OutReady = 1'b0;
        k = 0;
        for (c = 0; c < 6; c++) begin
            if (k < 3) begin
                drive(6 + k);
                InValid = 1'b1;
            end else begin
                InValid = 1'b0;
            end
            @(negedge Clk);
            acc = InValid && InReady;
            @(posedge Clk);
            #1;
            if (acc) k++;
        end
        check("bp_accepted", 64'(k), 64'(2));
        check("bp_inready",  64'(InReady), 64'(0));
        check("bp_outvalid_held", 64'(OutValid), 64'(1));
        p0 = popped;
        OutReady = 1'b1;
        c = 0;
        while (k < 3 && c < 20) begin
            drive(6 + k);
            InValid = 1'b1;
            @(negedge Clk);
            acc = InReady;
            @(posedge Clk);
            #1;
            if (acc) k++;
            c++;
        end
        InValid = 1'b0;
        drain();
        check("bp_popped", 64'(popped - p0), 64'(3));

        // Asynchronous reset with both stages full.
        OutReady = 1'b0;
        send(4);
        send(5);
        check("full_inready", 64'(InReady), 64'(0));
        #2;
        Reset = 1'b1;
        #1;
        check("async_reset_outvalid", 64'(OutValid), 64'(0));
        check("async_reset_inready",  64'(InReady),  64'(1));
        sb.delete();
        @(posedge Clk);
        #1;
        Reset    = 1'b0;
        OutReady = 1'b1;
        send(9);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/add_sub_stage3.md
# add_sub_stage3

Third pipeline stage of the floating-point add/subtract path. It consumes the aligned and conditionally inverted operands, the base exponent and the effective operation produced by the alignment stage. It performs the significand addition, normalisation, round-to-nearest-even and exponent adjustment, and emits a packed single-precision result. Internally it has two register stages with a valid/ready handshake so the unit can be back-pressured by the writeback logic.

## Interface
Parameters:
- DataSize, 32, packed result width
- FractionSize, 23, stored fraction bits
- MantissaSize, FractionSize+1, significand including hidden bit
- RoundingSize, MantissaSize+3, significand + guard + round + sticky
- ExponentSize, 8, exponent width

Ports:
- Clk  input  1  rising-edge clock (single clock domain)
- Reset  input  1  asynchronous, active-high reset
- InValid  input  1  upstream operands valid
- InReady  output  1  stage can accept this cycle
- Adder1  input  RoundingSize  aligned operand (possibly inverted)
- Adder2  input  RoundingSize  unaligned operand (possibly inverted)
- ExponentBase  input  ExponentSize  larger operand's exponent
- EffOperation  input  1  0 = effective add, 1 = effective subtract
- ResultSign  input  1  sign of the result, computed upstream
- OutValid  output  1  Result valid
- OutReady  input  1  downstream accepts
- Result  output  DataSize  packed {sign, exponent, fraction}
- Overflow  output  1  result saturated to infinity
- Underflow  output  1  result flushed to zero

## Operation
- Stage A, add:
  - Sum[RoundingSize:0] = Adder1 + Adder2 + EffOperation (28 bits).
  - Register Sum, ExponentBase, EffOperation and ResultSign.
- Stage B, normalise and round, combinational from the stage-A registers:
  - Effective add with Sum[27]=1: shift right by 1, OR the shifted-out bit into sticky, exponent+1.
  - Effective subtract: ignore Sum[27]. Zero-check Sum[26:0] first.
    - If zero: emit +0 (0x00000000) with no flags.
    - Otherwise: left-shift by lzc = leading zeros of Sum[26:0], and exponent = ExponentBase - lzc. Compute in ExponentSize+2-bit signed arithmetic.
  - After normalisation:
    - mantissa = bits[26:3]
    - G = bit2
    - R = bit1
    - S = bit0 OR any sticky collected during normalisation
  - Rounding, RNE: round up when G & (R | S | mantissa[0]).
    - If the mantissa overflows to 2.0, set mantissa = 1.0 and exponent+1.
  - Exponent ≥ 255: Result = {sign, 8'hFF, 0}, Overflow = 1.
  - Exponent ≤ 0: Result = {sign, 0, 0}, Underflow = 1. There are no denormals.
  - Register Result, Overflow and Underflow.
- Handshake:
  - advB = OutReady | ~OutValid
  - advA = advB | ~ValidA
  - InReady = advA
  - A transfer happens when InValid & InReady. Data is never dropped or duplicated.

## Timing
- Latency: 2 cycles from accepted input to OutValid, with no stall.
- Throughput: 1 result per cycle while OutReady = 1.
- While OutValid & ~OutReady:
  - Result, Overflow and Underflow hold stable.
  - Stage A holds if it is valid.
  - InReady = 0 once both stages are full.
- Reset state: OutValid = 0, ValidA = 0, Result = 0, Overflow = 0, Underflow = 0. InReady = 1 after reset.
- Reset asserted mid-operation discards all in-flight data immediately, asynchronously.
- When input acceptance and output consumption occur in the same cycle, both take effect and there is no bubble.

## Structure
- Shared package holds:
  - width constants (DataSize, FractionSize, MantissaSize, RoundingSize, ExponentSize)
  - ExpInf = 8'hFF
  - exponent bias 127
- One sub-module: leading_zero_counter, RoundingSize-bit input, 5-bit count output, purely combinational. It is reusable by the multiply/divide normaliser.

## Test plan
- 1.0+1.0: Adder1 = Adder2 = 27'h4000000, EffOperation = 0, ExponentBase = 127 → Result 0x40000000 two cycles later, no flags.
- 1.0−1.0: Adder1 = 27'h3FFFFFF, Adder2 = 27'h4000000, EffOperation = 1 → Result 0x00000000, Overflow = Underflow = 0.
- RNE carry-out: Adder1 = 0, Adder2 = {24'hFFFFFF, 3'b100}, EffOperation = 0, ExponentBase = 127 → tie with odd LSB rounds up → 0x40000000. Same operands with Adder2 = {24'hFFFFFE, 3'b100} → 0x3FFFFFFE (tie, even, no round).
- Overflow: ExponentBase = 254 with 1.0+1.0 → Result 0x7F800000, Overflow = 1.
- Underflow: ExponentBase = 1, EffOperation = 1, Adder1 = ~27'h4000000 (27-bit, = 27'h3FFFFFF), Adder2 = 27'h4800000 (i.e. 1.125−1.0 → Sum[26:0] = 27'h0800000, lzc = 3) → exponent ≤ 0 → Result 0x00000000, Underflow = 1.
- Back-pressure and reset:
  - Hold OutReady = 0 and present 3 back-to-back valid inputs → InReady drops after 2 are accepted.
  - Release OutReady → all 3 results emerge in order with no loss.
  - Separately, assert Reset with both stages full → OutValid = 0 immediately.
